// File: rtl/rv32_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv32_pkg
//  Description : Shared RV32I decode definitions. Holds the base-ISA opcode
//                values, the immediate-format enumeration, the registered
//                decoded-bundle struct and helpers that map an opcode to its
//                immediate format and legality.
//  Revision    : 1.0  initial release
// ============================================================================
package rv32_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_I    = 3'd0,
    IMM_S    = 3'd1,
    IMM_B    = 3'd2,
    IMM_U    = 3'd3,
    IMM_J    = 3'd4,
    IMM_NONE = 3'd5
  } imm_type_e;

  typedef struct packed {
    logic [XLEN-1:0]      pc;
    logic [31:0]          imm;
    logic [REG_IDX_W-1:0] rd;
    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic [6:0]           funct7;
    logic                 illegal;
  } decoded_t;

  // Immediate format selected by the major opcode. R-type, fence and
  // unknown opcodes all carry no immediate.
  function automatic imm_type_e imm_type_of(input logic [6:0] opcode);
    imm_type_e t;
    case (opcode)
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: t = IMM_I;
      OP_STORE:                            t = IMM_S;
      OP_BRANCH:                           t = IMM_B;
      OP_LUI, OP_AUIPC:                    t = IMM_U;
      OP_JAL:                              t = IMM_J;
      default:                             t = IMM_NONE;
    endcase
    return t;
  endfunction

  function automatic logic opcode_is_legal(input logic [6:0] opcode);
    logic legal;
    case (opcode)
      OP_LOAD, OP_IMM, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC,
      OP_JAL, OP_JALR, OP_REG, OP_FENCE, OP_SYSTEM: legal = 1'b1;
      default:                                      legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage
`default_nettype wire

// File: rtl/decode_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage_if
//  Description : Bundle of every bus-level connection of the decode stage:
//                fetch handshake, register-file read port, writeback snoop
//                and the decoded-bundle handshake towards execute.
//                modport slave  : the decode stage itself
//                modport master : the surrounding pipeline / environment
//  Ports (slave view):
//    in_valid/in_instr/in_pc  in   fetch request,   in_ready   out
//    rf_ren/rf_rs1/rf_rs2     out  register-file read request
//    rf_rs1v/rf_rs2v          in   register-file read data (1 cycle later)
//    wb_wen/wb_rd/wb_rdv      in   writeback snoop
//    out_*                    out  decoded bundle,   out_ready  in
//  Revision    : 1.0  initial release
// ============================================================================
interface decode_stage_if
  import rv32_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN,
  parameter int IDX_WIDTH  = REG_IDX_W
);
  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           in_instr;
  logic [DATA_WIDTH-1:0] in_pc;

  logic                  rf_ren;
  logic [IDX_WIDTH-1:0]  rf_rs1;
  logic [IDX_WIDTH-1:0]  rf_rs2;
  logic [DATA_WIDTH-1:0] rf_rs1v;
  logic [DATA_WIDTH-1:0] rf_rs2v;

  logic                  wb_wen;
  logic [IDX_WIDTH-1:0]  wb_rd;
  logic [DATA_WIDTH-1:0] wb_rdv;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_pc;
  logic [DATA_WIDTH-1:0] out_rs1v;
  logic [DATA_WIDTH-1:0] out_rs2v;
  logic [31:0]           out_imm;
  logic [IDX_WIDTH-1:0]  out_rd;
  logic [6:0]            out_opcode;
  logic [2:0]            out_funct3;
  logic [6:0]            out_funct7;
  logic                  out_illegal;

  modport slave (
    input  in_valid, in_instr, in_pc,
    output in_ready,
    output rf_ren, rf_rs1, rf_rs2,
    input  rf_rs1v, rf_rs2v,
    input  wb_wen, wb_rd, wb_rdv,
    output out_valid, out_pc, out_rs1v, out_rs2v, out_imm, out_rd,
    output out_opcode, out_funct3, out_funct7, out_illegal,
    input  out_ready
  );

  modport master (
    output in_valid, in_instr, in_pc,
    input  in_ready,
    input  rf_ren, rf_rs1, rf_rs2,
    output rf_rs1v, rf_rs2v,
    output wb_wen, wb_rd, wb_rdv,
    input  out_valid, out_pc, out_rs1v, out_rs2v, out_imm, out_rd,
    input  out_opcode, out_funct3, out_funct7, out_illegal,
    output out_ready
  );

endinterface
`default_nettype wire

// File: rtl/imm_gen.sv
`default_nettype none
// ============================================================================
//  Module      : imm_gen
//  Description : Combinational RV32I immediate generator. Produces the
//                sign-extended immediate for the instruction's format and
//                flags opcodes outside the RV32I base set.
//  Ports:
//    i_instr    in   32  instruction word
//    o_imm      out  32  sign-extended immediate (0 for R/fence/illegal)
//    o_illegal  out  1   opcode not in the base set
//  Revision    : 1.0  initial release
// ============================================================================
module imm_gen
  import rv32_pkg::*;
(
  input  wire logic [31:0] i_instr,
  output logic      [31:0] o_imm,
  output logic             o_illegal
);

  imm_type_e w_type;

  always_comb begin
    w_type    = imm_type_of(i_instr[6:0]);
    o_illegal = ~opcode_is_legal(i_instr[6:0]);
    o_imm     = '0;
    case (w_type)
      IMM_I: o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
      IMM_S: o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      IMM_B: o_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                      i_instr[30:25], i_instr[11:8], 1'b0};
      IMM_U: o_imm = {i_instr[31:12], 12'b0};
      IMM_J: o_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                      i_instr[20], i_instr[30:21], 1'b0};
      default: o_imm = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage
//  Description : RV32I decode stage. Accepts an instruction from fetch,
//                issues the register-file read in the same cycle, and one
//                cycle later presents a decoded bundle with forwarded
//                operands to execute. Writebacks are snooped so the
//                operands are never stale, including while stalled.
//  Ports:
//    clk   in   clock
//    rst   in   asynchronous active-high reset
//    bus   decode_stage_if.slave  (fetch, register file, writeback, execute)
//  Revision    : 1.0  initial release
// ============================================================================
module decode_stage
  import rv32_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN,
  parameter int NUM_REG    = 32,
  parameter int IDX_WIDTH  = $clog2(NUM_REG)
)(
  input  wire logic      clk,
  input  wire logic      rst,
  decode_stage_if.slave  bus
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic                  r_full;
  decoded_t              r_dec;
  logic [IDX_WIDTH-1:0]  r_rs1;
  logic [IDX_WIDTH-1:0]  r_rs2;
  // Operand override: when set, r_opN replaces the register-file output,
  // which is either stale (read-during-write) or no longer held valid.
  logic [DATA_WIDTH-1:0] r_op1;
  logic [DATA_WIDTH-1:0] r_op2;
  logic                  r_ovr1;
  logic                  r_ovr2;

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  logic w_accept;
  logic w_fire;
  logic w_in_ready;

  assign w_in_ready    = ~r_full | bus.out_ready;
  assign w_accept      = bus.in_valid & w_in_ready;
  assign w_fire        = r_full & bus.out_ready;
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_full;

  // Register file is read only on accept so its outputs hold during a stall.
  logic [IDX_WIDTH-1:0] w_rs1_new;
  logic [IDX_WIDTH-1:0] w_rs2_new;

  assign w_rs1_new  = bus.in_instr[19:15];
  assign w_rs2_new  = bus.in_instr[24:20];
  assign bus.rf_ren = w_accept;
  assign bus.rf_rs1 = w_rs1_new;
  assign bus.rf_rs2 = w_rs2_new;

  // --------------------------------------------------------------------------
  // Field decode of the incoming instruction
  // --------------------------------------------------------------------------
  logic [31:0] w_imm;
  logic        w_illegal;
  decoded_t    w_dec;

  imm_gen u_imm_gen (
    .i_instr   (bus.in_instr),
    .o_imm     (w_imm),
    .o_illegal (w_illegal)
  );

  always_comb begin
    w_dec         = '0;
    w_dec.pc      = bus.in_pc;
    w_dec.imm     = w_imm;
    w_dec.opcode  = bus.in_instr[6:0];
    w_dec.funct3  = bus.in_instr[14:12];
    w_dec.funct7  = bus.in_instr[31:25];
    w_dec.illegal = w_illegal;
    // Stores and branches reuse instr[11:7] as immediate bits, not a target.
    if ((bus.in_instr[6:0] == OP_STORE) || (bus.in_instr[6:0] == OP_BRANCH))
      w_dec.rd = '0;
    else
      w_dec.rd = bus.in_instr[11:7];
  end

  // Same-edge bypass: the register file returns the pre-write value when a
  // writeback lands on the read edge, so catch the new value here.
  logic w_byp1;
  logic w_byp2;

  assign w_byp1 = bus.wb_wen && (bus.wb_rd == w_rs1_new) && (w_rs1_new != '0);
  assign w_byp2 = bus.wb_wen && (bus.wb_rd == w_rs2_new) && (w_rs2_new != '0);

  // --------------------------------------------------------------------------
  // Operand forwarding for the held instruction
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] w_base1;
  logic [DATA_WIDTH-1:0] w_base2;
  logic [DATA_WIDTH-1:0] w_fwd1;
  logic [DATA_WIDTH-1:0] w_fwd2;

  always_comb begin
    w_base1 = r_ovr1 ? r_op1 : bus.rf_rs1v;
    w_base2 = r_ovr2 ? r_op2 : bus.rf_rs2v;

    if (r_rs1 == '0)
      w_fwd1 = '0;
    else if (bus.wb_wen && (bus.wb_rd == r_rs1))
      w_fwd1 = bus.wb_rdv;
    else
      w_fwd1 = w_base1;

    if (r_rs2 == '0)
      w_fwd2 = '0;
    else if (bus.wb_wen && (bus.wb_rd == r_rs2))
      w_fwd2 = bus.wb_rdv;
    else
      w_fwd2 = w_base2;
  end

  assign bus.out_rs1v    = w_fwd1;
  assign bus.out_rs2v    = w_fwd2;
  assign bus.out_pc      = r_dec.pc;
  assign bus.out_imm     = r_dec.imm;
  assign bus.out_rd      = r_dec.rd;
  assign bus.out_opcode  = r_dec.opcode;
  assign bus.out_funct3  = r_dec.funct3;
  assign bus.out_funct7  = r_dec.funct7;
  assign bus.out_illegal = r_dec.illegal;

  // --------------------------------------------------------------------------
  // Sequential update
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full <= 1'b0;
      r_dec  <= '0;
      r_rs1  <= '0;
      r_rs2  <= '0;
      r_op1  <= '0;
      r_op2  <= '0;
      r_ovr1 <= 1'b0;
      r_ovr2 <= 1'b0;
    end else if (w_accept) begin
      // Covers both a fresh load and a back-to-back fire+accept.
      r_full <= 1'b1;
      r_dec  <= w_dec;
      r_rs1  <= w_rs1_new;
      r_rs2  <= w_rs2_new;
      r_op1  <= bus.wb_rdv;
      r_op2  <= bus.wb_rdv;
      r_ovr1 <= w_byp1;
      r_ovr2 <= w_byp2;
    end else if (w_fire) begin
      r_full <= 1'b0;
    end else if (r_full) begin
      // Stalled: freeze the forwarded view so writebacks are not lost.
      r_op1  <= w_fwd1;
      r_op2  <= w_fwd2;
      r_ovr1 <= 1'b1;
      r_ovr2 <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode_stage
//  Description : Directed self-checking bench for decode_stage with a
//                behavioural 1-cycle synchronous register file.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_decode_stage;
  import rv32_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  decode_stage_if #(.DATA_WIDTH(32), .IDX_WIDTH(5)) bus ();

  decode_stage #(.DATA_WIDTH(32), .NUM_REG(32), .IDX_WIDTH(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: read returns the pre-write value on a collision.
  logic [31:0] rf_mem [32];
  always @(posedge clk) begin
    if (bus.rf_ren) begin
      bus.rf_rs1v <= rf_mem[bus.rf_rs1];
      bus.rf_rs2v <= rf_mem[bus.rf_rs2];
    end
    if (bus.wb_wen && (bus.wb_rd != 5'd0))
      rf_mem[bus.wb_rd] <= bus.wb_rdv;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one instruction with execute ready, and take it on the next edge.
  task automatic send(input logic [31:0] instr, input logic [31:0] pc);
    bus.in_valid  = 1'b1;
    bus.in_instr  = instr;
    bus.in_pc     = pc;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid  = 1'b0;
    #1;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_pc     = '0;
    bus.wb_wen    = 1'b0;
    bus.wb_rd     = '0;
    bus.wb_rdv    = '0;
    bus.out_ready = 1'b0;

    // Preload x1..x4 through the writeback port while in reset.
    for (int i = 1; i <= 4; i++) begin
      bus.wb_wen = 1'b1;
      bus.wb_rd  = 5'(i);
      bus.wb_rdv = (i == 1) ? 32'd10 : 32'(i * 16);
      tick();
    end
    bus.wb_wen = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    chk("rst_out_pc",    bus.out_pc,             32'd0);
    chk("rst_out_imm",   bus.out_imm,            32'd0);
    rst = 1'b0;
    tick();

    // ADDI x5,x1,7
    bus.in_valid  = 1'b1;
    bus.in_instr  = 32'h00708293;
    bus.in_pc     = 32'h100;
    bus.out_ready = 1'b1;
    #1;
    chk("addi_rf_ren", {31'd0, bus.rf_ren}, 32'd1);
    chk("addi_rf_rs1", {27'd0, bus.rf_rs1}, 32'd1);
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("addi_valid",   {31'd0, bus.out_valid},   32'd1);
    chk("addi_rs1v",    bus.out_rs1v,             32'd10);
    chk("addi_imm",     bus.out_imm,              32'd7);
    chk("addi_rd",      {27'd0, bus.out_rd},      32'd5);
    chk("addi_illegal", {31'd0, bus.out_illegal}, 32'd0);
    chk("addi_pc",      bus.out_pc,               32'h100);
    tick();
    chk("addi_drained", {31'd0, bus.out_valid}, 32'd0);

    // ADDI x6,x1,0 accepted while x1 is being written with 0x55
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h00008313;
    bus.in_pc    = 32'h104;
    bus.wb_wen   = 1'b1;
    bus.wb_rd    = 5'd1;
    bus.wb_rdv   = 32'h55;
    tick();
    bus.in_valid = 1'b0;
    bus.wb_wen   = 1'b0;
    #1;
    chk("byp_rs1v", bus.out_rs1v, 32'h55);
    tick();

    // ADD x7,x0,x2 with a three-cycle stall and a writeback to x2 mid-stall
    bus.in_valid  = 1'b1;
    bus.in_instr  = 32'h002003B3;
    bus.in_pc     = 32'h200;
    bus.out_ready = 1'b0;
    tick();
    bus.in_instr = 32'h00118593;   // next instruction waits at the input
    bus.in_pc    = 32'h204;
    #1;
    chk("stall1_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("stall1_rf_ren",   {31'd0, bus.rf_ren},   32'd0);
    chk("stall1_rs2v",     bus.out_rs2v,          32'h20);
    chk("stall1_rs1v",     bus.out_rs1v,          32'd0);
    tick();
    bus.wb_wen = 1'b1;
    bus.wb_rd  = 5'd2;
    bus.wb_rdv = 32'h99;
    #1;
    chk("stall2_rs2v",     bus.out_rs2v,          32'h99);
    chk("stall2_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("stall2_rf_ren",   {31'd0, bus.rf_ren},   32'd0);
    tick();
    bus.wb_wen = 1'b0;
    #1;
    chk("stall3_rs2v",  bus.out_rs2v,         32'h99);
    chk("stall3_rd",    {27'd0, bus.out_rd},  32'd7);
    chk("stall3_valid", {31'd0, bus.out_valid}, 32'd1);
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("fire_rs2v",  bus.out_rs2v,           32'h99);
    chk("fire_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("fire_pc",    bus.out_pc,             32'h200);
    tick();
    chk("fire_drained", {31'd0, bus.out_valid}, 32'd0);

    // Four back-to-back ADDI x(8+k),x3,k
    for (int k = 0; k < 4; k++) begin
      bus.in_valid  = 1'b1;
      bus.in_instr  = (32'(k) << 20) | (32'd3 << 15) | (32'(8 + k) << 7) | 32'h13;
      bus.in_pc     = 32'h300 + 32'(4 * k);
      bus.out_ready = 1'b1;
      #1;
      chk("b2b_in_ready", {31'd0, bus.in_ready}, 32'd1);
      tick();
      chk("b2b_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("b2b_pc",    bus.out_pc,             32'h300 + 32'(4 * k));
      chk("b2b_rs1v",  bus.out_rs1v,           32'h30);
      chk("b2b_imm",   bus.out_imm,            32'(k));
    end
    bus.in_valid = 1'b0;
    tick();
    chk("b2b_drained", {31'd0, bus.out_valid}, 32'd0);

    // ADDI x9,x0,5 with a writeback to x0 in flight
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h00500493;
    bus.in_pc    = 32'h380;
    bus.wb_wen   = 1'b1;
    bus.wb_rd    = 5'd0;
    bus.wb_rdv   = 32'hFFFFFFFF;
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("x0_rs1v", bus.out_rs1v,        32'd0);
    chk("x0_imm",  bus.out_imm,         32'd5);
    chk("x0_rd",   {27'd0, bus.out_rd}, 32'd9);
    bus.wb_wen = 1'b0;

    // Illegal opcode and the immediate formats
    send(32'h0000007F, 32'h400);
    chk("ill_illegal", {31'd0, bus.out_illegal}, 32'd1);
    chk("ill_imm",     bus.out_imm,              32'd0);
    chk("ill_valid",   {31'd0, bus.out_valid},   32'd1);
    chk("ill_opcode",  {25'd0, bus.out_opcode},  32'h7F);

    send(32'hFFF00093, 32'h404);       // addi x1,x0,-1
    chk("i_neg_imm", bus.out_imm, 32'hFFFFFFFF);

    send(32'hFE208CE3, 32'h408);       // beq x1,x2,-8
    chk("b_imm",     bus.out_imm,              32'hFFFFFFF8);
    chk("b_rd",      {27'd0, bus.out_rd},      32'd0);
    chk("b_illegal", {31'd0, bus.out_illegal}, 32'd0);

    send(32'h12345537, 32'h40C);       // lui x10,0x12345
    chk("u_imm", bus.out_imm,         32'h12345000);
    chk("u_rd",  {27'd0, bus.out_rd}, 32'd10);

    send(32'h0020A423, 32'h410);       // sw x2,8(x1)
    chk("s_imm",    bus.out_imm,            32'd8);
    chk("s_rd",     {27'd0, bus.out_rd},    32'd0);
    chk("s_funct3", {29'd0, bus.out_funct3}, 32'd2);

    send(32'h001000EF, 32'h414);       // jal x1,+0x800
    chk("j_imm", bus.out_imm,         32'h800);
    chk("j_rd",  {27'd0, bus.out_rd}, 32'd1);
    chk("j_pc",  bus.out_pc,          32'h414);
    tick();
    chk("imm_drained", {31'd0, bus.out_valid}, 32'd0);

    // Asynchronous reset while full and stalled
    bus.in_valid  = 1'b1;
    bus.in_instr  = 32'h00708293;
    bus.in_pc     = 32'h500;
    bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("prerst_valid", {31'd0, bus.out_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid",    {31'd0, bus.out_valid}, 32'd0);
    chk("arst_in_ready", {31'd0, bus.in_ready},  32'd1);
    chk("arst_pc",       bus.out_pc,             32'd0);
    tick();
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("postrst_valid",    {31'd0, bus.out_valid}, 32'd0);
    chk("postrst_in_ready", {31'd0, bus.in_ready},  32'd1);
    tick();
    chk("postrst_valid2", {31'd0, bus.out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/decode_stage.md
Name: decode_stage

Overview:
RV32I decode stage. Accepts fetched instructions over a valid/ready handshake and drives the read ports of the register file. The register file has 1-cycle synchronous reads; this stage absorbs that latency. It forwards writeback results so operands are never stale, then presents a decoded bundle (operands, immediate, fields) to execute over a second valid/ready handshake.

Parameters:
data_width, 32, operand/PC width
num_reg, 32, architectural register count
idx_width, $clog2(num_reg), register index width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  fetch has an instruction
in_ready  out  1  stage can accept
in_instr  in  32  instruction word
in_pc  in  data_width  instruction PC
rf_ren  out  1  register file read enable
rf_rs1, rf_rs2  out  idx_width  register file read addresses
rf_rs1v, rf_rs2v  in  data_width  register file read data (valid the cycle after rf_ren)
wb_wen  in  1  writeback write enable (same signal driving the register file write)
wb_rd  in  idx_width  writeback destination
wb_rdv  in  data_width  writeback value
out_valid  out  1  decoded bundle valid
out_ready  in  1  execute accepts
out_pc  out  data_width  PC
out_rs1v, out_rs2v  out  data_width  forwarded operands
out_imm  out  32  sign-extended immediate
out_rd  out  idx_width  destination (0 for S/B types)
out_opcode  out  7  instr[6:0]
out_funct3  out  3  instr[14:12]
out_funct7  out  7  instr[31:25]
out_illegal  out  1  opcode not in RV32I base set

Behaviour:
- Clock is clk. Reset is asynchronous and active-high on rst.
- Reset: full=0, out_valid=0, all out_* registers 0, ovr1/ovr2=0. Reset mid-operation drops the held instruction with no replay.
- Handshake signals:
  - in_ready = !full || out_ready. accept = in_valid && in_ready. fire = out_valid && out_ready.
  - out_valid = full.
- Register file drive (combinational):
  - rf_ren = accept.
  - rf_rs1 = in_instr[19:15], rf_rs2 = in_instr[24:20].
  - rf_ren is low during a stall, so the register file holds its outputs.
- Accept edge (cycle N):
  - Register pc, rd, opcode, funct3, funct7, imm, illegal, rs1/rs2 indices; full<=1.
  - Same-edge bypass: the register file returns the old value on a read-during-write. Therefore, if wb_wen && wb_rd==rs1 && rs1!=0, then op1_q<=wb_rdv and ovr1<=1; otherwise ovr1<=0. rs2 is handled identically.
- Output cycle (N+1 onward), combinational:
  - base1 = ovr1 ? op1_q : rf_rs1v.
  - out_rs1v = (rs1==0) ? 0 : (wb_wen && wb_rd==rs1) ? wb_rdv : base1.
  - rs2 is handled identically.
  - Latency: accept to out_valid is 1 cycle.
- Stall (full && !out_ready): op1_q<=out_rs1v, ovr1<=1 (same for rs2). Writebacks during a stall are therefore captured.
- Exit:
  - fire && !accept: full<=0.
  - fire && accept: back-to-back; the new instruction loads with no bubble.
- x0: an operand index of 0 always yields 0, regardless of wb_rd==0 writes.
- Immediate by opcode, always sign-extended from instr[31]:
  - I (0000011, 0010011, 1100111, 1110011): instr[31:20].
  - S (0100011): {instr[31:25], instr[11:7]}.
  - B (1100011): {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U (0110111, 0010111): {instr[31:12], 12'b0}.
  - J (1101111): {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - R (0110011) and fence (0001111): 0.
  - Any other opcode: out_illegal=1, imm=0. The bundle still flows.
- No internal stall logic for load-use hazards; downstream hazard control owns that.

Decomposition:
- Package rv32_pkg:
  - Opcode localparams (OP_LOAD, OP_IMM, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_REG, OP_FENCE, OP_SYSTEM).
  - imm_type_e enum (IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE).
  - Packed struct decoded_t (pc, imm, rd, opcode, funct3, funct7, illegal).
- One combinational sub-module, imm_gen: instr in, imm plus illegal out.

Test Plan:
- Issue ADDI x5,x1,7 (0x00708293) with x1=10, out_ready=1 -> rf_ren=1 at accept. Next cycle out_valid=1, out_rs1v=10, out_imm=7, out_rd=5, out_illegal=0.
- Accept an instruction reading x1 while wb_wen=1, wb_rd=1, wb_rdv=0x55 in the same cycle -> out_rs1v=0x55, not the old register value.
- Hold out_ready=0 for 3 cycles after accept of an instruction reading x2; pulse wb x2=0x99 in stall cycle 2 -> in_ready=0 and rf_ren=0 throughout. out_rs2v=0x99 from that cycle on, including at fire.
- Send back-to-back instructions, out_ready=1, in_valid=1 for 4 cycles -> 4 consecutive out_valid cycles with no bubble, and PCs in order.
- Read x0 while wb_wen=1, wb_rd=0, wb_rdv=0xFFFFFFFF -> out_rs1v=0. Issue instr 0x0000007F -> out_illegal=1, out_imm=0.
- Assert rst asynchronously while full and stalled -> out_valid=0 before the next clk edge. After release, in_ready=1 and the old instruction never appears.
